// File: rtl/up_packet_bridge.sv
// up_packet_bridge
//
// Bridges an asynchronous byte-wide microprocessor handshake bus to a simple
// 32-bit register-bank request/response interface. The host sends a command
// packet (cmd, addr, data[7:0] .. data[31:24]). The block executes a register
// read (cmd 0) or write (cmd 1) and then returns a reply packet to the host
// (data[7:0] .. data[31:24], status[7:0] .. status[31:24]).
//
// Configuration macro: UP_TIMEOUT_EN
//   When defined, a stall counter aborts any state that waits longer than
//   TIMEOUT_CYCLES and reports it in reply status bit 1. When undefined, the
//   block waits indefinitely and status bit 1 is always 0.
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous active-high reset
//   async_uP_start       host transaction start (asynchronous)
//   async_uP_handshake_1 host strobe/ack (asynchronous)
//   async_uP_RW          1 = host drives the bus (asynchronous)
//   uP_data_in   [7:0]   byte from host
//   uP_data_out  [7:0]   byte to host
//   uP_data_oe           enable for the external tristate driver
//   uP_handshake_2       block strobe/ack
//   uP_ack               transaction complete, held until next start
//   reg_address  [7:0]   register-bank address
//   reg_wr_data  [31:0]  register-bank write data
//   reg_write, reg_read  single-cycle register-bank strobes
//   reg_rd_data  [31:0]  register-bank read data
//   reg_status   [31:0]  register-bank status
//   reg_done             register-bank response valid
module up_packet_bridge #(
  parameter int NOS_CMD_BYTES   = 6,
  parameter int NOS_REPLY_BYTES = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  input  logic [7:0]  uP_data_in,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_wr_data,
  output logic        reg_write,
  output logic        reg_read,
  input  logic [31:0] reg_rd_data,
  input  logic [31:0] reg_status,
  input  logic        reg_done
);

  typedef enum logic [3:0] {
    IDLE,
    RX_WAIT_H1,
    RX_WAIT_H1_LOW,
    EXECUTE,
    WAIT_DONE,
    TX_DRIVE,
    TX_WAIT_H1,
    TX_WAIT_H1_LOW,
    COMPLETE
  } state_t;

  localparam logic [7:0] CMD_LAST   = 8'(NOS_CMD_BYTES - 1);
  localparam logic [7:0] REPLY_LAST = 8'(NOS_REPLY_BYTES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] reply_data_q, reply_data_d;
  logic [31:0] status_q, status_d;
  logic        bad_cmd_q, bad_cmd_d;
  logic        hs2_q, hs2_d;
  logic        ack_q, ack_d;
  logic        oe_q, oe_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        drive_phase_q, drive_phase_d;
  logic        reg_write_q, reg_write_d;
  logic        reg_read_q, reg_read_d;

  logic        start_meta_q, start_sync_q, start_prev_q;
  logic        h1_meta_q, h1_sync_q;
  logic        rw_meta_q, rw_sync_q;
  logic        start_rise;

  logic        timeout_hit;
  logic        timeout_flag;
  logic [31:0] reply_status;
  logic [7:0]  reply_byte;
  logic        in_tx_state;

  // Two-flop synchronizers; start gets a third flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_prev_q <= 1'b0;
      h1_meta_q    <= 1'b0;
      h1_sync_q    <= 1'b0;
      rw_meta_q    <= 1'b0;
      rw_sync_q    <= 1'b0;
    end else begin
      start_meta_q <= async_uP_start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
      h1_meta_q    <= async_uP_handshake_1;
      h1_sync_q    <= h1_meta_q;
      rw_meta_q    <= async_uP_RW;
      rw_sync_q    <= rw_meta_q;
    end
  end

  assign start_rise = start_sync_q & ~start_prev_q;

`ifdef UP_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_flag_q, timeout_flag_d;

  assign timeout_hit  = (state_q != IDLE) && (tmo_cnt_q == TMO_LAST);
  assign timeout_flag = timeout_flag_q;

  // Stall counter restarts whenever the state changes; the flag is sticky
  // for the current transaction and cleared by the next accepted start.
  always_comb begin
    tmo_cnt_d      = tmo_cnt_q + 32'd1;
    timeout_flag_d = timeout_flag_q;
    if ((state_d != state_q) || (state_q == IDLE)) begin
      tmo_cnt_d = '0;
    end
    if ((state_q == IDLE) && start_rise) begin
      timeout_flag_d = 1'b0;
    end else if (timeout_hit) begin
      timeout_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  assign reply_status = {status_q[31:2], timeout_flag, bad_cmd_q};

  // Reply stream: four data bytes, then four status bytes, LSB first.
  always_comb begin
    reply_byte = 8'h00;
    case (cnt_q)
      8'd0:    reply_byte = reply_data_q[7:0];
      8'd1:    reply_byte = reply_data_q[15:8];
      8'd2:    reply_byte = reply_data_q[23:16];
      8'd3:    reply_byte = reply_data_q[31:24];
      8'd4:    reply_byte = reply_status[7:0];
      8'd5:    reply_byte = reply_status[15:8];
      8'd6:    reply_byte = reply_status[23:16];
      8'd7:    reply_byte = reply_status[31:24];
      default: reply_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    reply_data_d  = reply_data_q;
    status_d      = status_q;
    bad_cmd_d     = bad_cmd_q;
    hs2_d         = hs2_q;
    ack_d         = ack_q;
    oe_d          = 1'b0;
    data_out_d    = data_out_q;
    drive_phase_d = 1'b0;
    reg_write_d   = 1'b0;
    reg_read_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d      = RX_WAIT_H1;
          ack_d        = 1'b0;
          cnt_d        = '0;
          bad_cmd_d    = 1'b0;
          status_d     = '0;
          reply_data_d = '0;
          hs2_d        = 1'b0;
        end
      end

      RX_WAIT_H1: begin
        if (h1_sync_q && rw_sync_q) begin
          case (cnt_q)
            8'd0:    cmd_d          = uP_data_in;
            8'd1:    addr_d         = uP_data_in;
            8'd2:    wdata_d[7:0]   = uP_data_in;
            8'd3:    wdata_d[15:8]  = uP_data_in;
            8'd4:    wdata_d[23:16] = uP_data_in;
            8'd5:    wdata_d[31:24] = uP_data_in;
            default: ;
          endcase
          hs2_d   = 1'b1;
          state_d = RX_WAIT_H1_LOW;
        end
      end

      RX_WAIT_H1_LOW: begin
        if (!h1_sync_q) begin
          hs2_d = 1'b0;
          if (cnt_q == CMD_LAST) begin
            cnt_d   = '0;
            state_d = EXECUTE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = RX_WAIT_H1;
          end
        end
      end

      EXECUTE: begin
        if (cmd_q == 8'd0) begin
          reg_read_d = 1'b1;
          state_d    = WAIT_DONE;
        end else if (cmd_q == 8'd1) begin
          reg_write_d = 1'b1;
          state_d     = WAIT_DONE;
        end else begin
          bad_cmd_d    = 1'b1;
          reply_data_d = '0;
          state_d      = TX_DRIVE;
        end
      end

      WAIT_DONE: begin
        if (reg_done) begin
          reply_data_d = (cmd_q == 8'd0) ? reg_rd_data : wdata_q;
          status_d     = reg_status;
          state_d      = TX_DRIVE;
        end
      end

      // Data is put on the bus one cycle before the strobe so it is settled
      // when the host sees handshake_2 rise.
      TX_DRIVE: begin
        if (!rw_sync_q) begin
          oe_d       = 1'b1;
          data_out_d = reply_byte;
          if (drive_phase_q) begin
            hs2_d   = 1'b1;
            state_d = TX_WAIT_H1;
          end else begin
            drive_phase_d = 1'b1;
          end
        end
      end

      TX_WAIT_H1: begin
        oe_d = oe_q;
        if (h1_sync_q) begin
          hs2_d   = 1'b0;
          state_d = TX_WAIT_H1_LOW;
        end
      end

      TX_WAIT_H1_LOW: begin
        oe_d = oe_q;
        if (!h1_sync_q) begin
          if (cnt_q == REPLY_LAST) begin
            cnt_d   = '0;
            oe_d    = 1'b0;
            state_d = COMPLETE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = TX_DRIVE;
          end
        end
      end

      COMPLETE: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A stall before the reply starts still answers the host (with zero
    // data); a stall during the reply abandons the remaining bytes.
    if (timeout_hit) begin
      case (state_q)
        RX_WAIT_H1, RX_WAIT_H1_LOW, EXECUTE, WAIT_DONE: begin
          state_d      = TX_DRIVE;
          cnt_d        = '0;
          hs2_d        = 1'b0;
          reply_data_d = '0;
          reg_read_d   = 1'b0;
          reg_write_d  = 1'b0;
        end
        TX_DRIVE, TX_WAIT_H1, TX_WAIT_H1_LOW: begin
          state_d = COMPLETE;
          cnt_d   = '0;
          hs2_d   = 1'b0;
          oe_d    = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      reply_data_q  <= '0;
      status_q      <= '0;
      bad_cmd_q     <= 1'b0;
      hs2_q         <= 1'b0;
      ack_q         <= 1'b0;
      oe_q          <= 1'b0;
      data_out_q    <= '0;
      drive_phase_q <= 1'b0;
      reg_write_q   <= 1'b0;
      reg_read_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      reply_data_q  <= reply_data_d;
      status_q      <= status_d;
      bad_cmd_q     <= bad_cmd_d;
      hs2_q         <= hs2_d;
      ack_q         <= ack_d;
      oe_q          <= oe_d;
      data_out_q    <= data_out_d;
      drive_phase_q <= drive_phase_d;
      reg_write_q   <= reg_write_d;
      reg_read_q    <= reg_read_d;
    end
  end

  assign in_tx_state = (state_q == TX_DRIVE) || (state_q == TX_WAIT_H1) ||
                       (state_q == TX_WAIT_H1_LOW);

  // The synchronized RW gate is applied combinationally so the bus is
  // released the same cycle the host claims it.
  assign uP_data_oe     = oe_q & ~rw_sync_q & in_tx_state;
  assign uP_data_out    = data_out_q;
  assign uP_handshake_2 = hs2_q;
  assign uP_ack         = ack_q;
  assign reg_address    = addr_q;
  assign reg_wr_data    = wdata_q;
  assign reg_write      = reg_write_q;
  assign reg_read       = reg_read_q;

endmodule

// File: tb/tb_up_packet_bridge.sv
// tb_up_packet_bridge
//
// Directed bench for up_packet_bridge. A behavioural host drives the
// asynchronous handshake bus and a small register-bank model answers the
// reg_read/reg_write strobes a few cycles later with a fixed status word.
module tb_up_packet_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_in = 1'b0;
  logic        h1_in = 1'b0;
  logic        rw_in = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  uP_data_out;
  logic        uP_data_oe;
  logic        uP_handshake_2;
  logic        uP_ack;
  logic [7:0]  reg_address;
  logic [31:0] reg_wr_data;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_rd_data = 32'h0;
  logic [31:0] reg_status = 32'hA5A5_5A5F;
  logic        reg_done = 1'b0;

  localparam logic [31:0] STATUS_OK = 32'hA5A5_5A5C;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem [0:255];
  bit          busy = 1'b0;
  int          dly = 0;
  bit          model_hold = 1'b0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_wdata = 32'h0;

  up_packet_bridge #(
    .NOS_CMD_BYTES(6),
    .NOS_REPLY_BYTES(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .async_uP_start(start_in),
    .async_uP_handshake_1(h1_in),
    .async_uP_RW(rw_in),
    .uP_data_in(data_in),
    .uP_data_out(uP_data_out),
    .uP_data_oe(uP_data_oe),
    .uP_handshake_2(uP_handshake_2),
    .uP_ack(uP_ack),
    .reg_address(reg_address),
    .reg_wr_data(reg_wr_data),
    .reg_write(reg_write),
    .reg_read(reg_read),
    .reg_rd_data(reg_rd_data),
    .reg_status(reg_status),
    .reg_done(reg_done)
  );

  always #5 clk = ~clk;

  // Register-bank model: answers a strobe four cycles later unless held.
  always @(posedge clk) begin
    reg_done <= 1'b0;
    if (reset) begin
      busy <= 1'b0;
      dly  <= 0;
    end else if (reg_write || reg_read) begin
      if (reg_write) mem[reg_address] <= reg_wr_data;
      busy <= 1'b1;
      dly  <= 3;
    end else if (busy && !model_hold) begin
      if (dly == 0) begin
        reg_done    <= 1'b1;
        reg_rd_data <= mem[reg_address];
        busy        <= 1'b0;
      end else begin
        dly <= dly - 1;
      end
    end
  end

  // Strobe monitor: counts high cycles of each strobe.
  always @(negedge clk) begin
    if (reg_write) begin
      wr_cnt     = wr_cnt + 1;
      last_addr  = reg_address;
      last_wdata = reg_wr_data;
    end
    if (reg_read) begin
      rd_cnt    = rd_cnt + 1;
      last_addr = reg_address;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_hs2(input logic val);
    int n;
    n = 0;
    while (uP_handshake_2 !== val && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (uP_handshake_2 !== val) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL hs2_wait: got %b expected %b", uP_handshake_2, val);
    end
  endtask

  task automatic host_start();
    start_in = 1'b1;
    repeat (4) @(negedge clk);
    start_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    rw_in   = 1'b1;
    @(negedge clk);
    h1_in = 1'b1;
    wait_hs2(1'b1);
    h1_in = 1'b0;
    wait_hs2(1'b0);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic oe);
    rw_in = 1'b0;
    wait_hs2(1'b1);
    b  = uP_data_out;
    oe = uP_data_oe;
    h1_in = 1'b1;
    wait_hs2(1'b0);
    h1_in = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] addr,
                          input logic [31:0] data, input bit repulse);
    host_start();
    send_byte(cmd);
    send_byte(addr);
    if (repulse) host_start();
    for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
  endtask

  task automatic recv_reply(output logic [63:0] reply, output bit oe_ok);
    logic [7:0] b;
    logic       oe;
    int         n;
    oe_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      recv_byte(b, oe);
      reply[8*i +: 8] = b;
      if (oe !== 1'b1) oe_ok = 1'b0;
    end
    n = 0;
    while (uP_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({uP_ack, uP_handshake_2, uP_data_oe, reg_write, reg_read} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {uP_ack, uP_handshake_2, uP_data_oe, reg_write, reg_read});
    end
    n_cmp++;
    if (reg_address !== 8'h00 || reg_wr_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_reg: got %h/%h expected 00/00000000", reg_address, reg_wr_data);
    end
    n_cmp++;
    if (uP_data_out !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_dout: got %h expected 00", uP_data_out);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [63:0] reply;
    bit          oe_ok;
    int          wb, rb;
    wb = wr_cnt;
    rb = rd_cnt;
    send_cmd(8'd1, 8'h10, 32'd100, 1'b0);
    recv_reply(reply, oe_ok);
    n_cmp++;
    if ((wr_cnt - wb) !== 1) begin
      n_fail++;
      $display("[TB] FAIL write_pulse: got %0d expected 1", wr_cnt - wb);
    end
    n_cmp++;
    if ((rd_cnt - rb) !== 0) begin
      n_fail++;
      $display("[TB] FAIL write_no_read: got %0d expected 0", rd_cnt - rb);
    end
    n_cmp++;
    if (last_addr !== 8'h10 || last_wdata !== 32'd100) begin
      n_fail++;
      $display("[TB] FAIL write_req: got %h/%h expected 10/00000064", last_addr, last_wdata);
    end
    n_cmp++;
    if (reply !== {STATUS_OK, 32'd100}) begin
      n_fail++;
      $display("[TB] FAIL write_reply: got %h expected %h", reply, {STATUS_OK, 32'd100});
    end
    n_cmp++;
    if (oe_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL write_oe: got %b expected 1", oe_ok);
    end
    n_cmp++;
    if (uP_ack !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL write_ack: got %b expected 1", uP_ack);
    end
  endtask

  task automatic test_read();
    logic [63:0] reply;
    bit          oe_ok;
    int          wb, rb;
    wb = wr_cnt;
    rb = rd_cnt;
    // A second start pulse mid-packet must be ignored.
    send_cmd(8'd0, 8'h10, 32'h0, 1'b1);
    recv_reply(reply, oe_ok);
    n_cmp++;
    if ((rd_cnt - rb) !== 1 || (wr_cnt - wb) !== 0) begin
      n_fail++;
      $display("[TB] FAIL read_pulse: got rd %0d wr %0d expected rd 1 wr 0", rd_cnt - rb, wr_cnt - wb);
    end
    n_cmp++;
    if (last_addr !== 8'h10) begin
      n_fail++;
      $display("[TB] FAIL read_addr: got %h expected 10", last_addr);
    end
    n_cmp++;
    if (reply !== {STATUS_OK, 32'h0000_0064}) begin
      n_fail++;
      $display("[TB] FAIL read_reply: got %h expected %h", reply, {STATUS_OK, 32'h0000_0064});
    end
    n_cmp++;
    if (uP_ack !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL read_ack: got %b expected 1", uP_ack);
    end
  endtask

  task automatic test_bad_cmd();
    logic [63:0] reply;
    bit          oe_ok;
    int          wb, rb;
    wb = wr_cnt;
    rb = rd_cnt;
    send_cmd(8'd7, 8'h10, 32'h1111_2222, 1'b0);
    recv_reply(reply, oe_ok);
    n_cmp++;
    if ((rd_cnt - rb) !== 0 || (wr_cnt - wb) !== 0) begin
      n_fail++;
      $display("[TB] FAIL bad_strobe: got rd %0d wr %0d expected 0 0", rd_cnt - rb, wr_cnt - wb);
    end
    n_cmp++;
    if (reply !== {32'h0000_0001, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL bad_reply: got %h expected %h", reply, {32'h0000_0001, 32'h0});
    end
    n_cmp++;
    if (uP_ack !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bad_ack: got %b expected 1", uP_ack);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [63:0] reply;
    bit          oe_ok;
    int          wb, rb;
    wb = wr_cnt;
    rb = rd_cnt;
    host_start();
    send_byte(8'd1);
    send_byte(8'h50);
    send_byte(8'hAA);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({uP_ack, uP_handshake_2, uP_data_oe, reg_write, reg_read} !== 5'b0 ||
        reg_address !== 8'h00 || reg_wr_data !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL midreset_out: got %b %h %h expected all zero",
               {uP_ack, uP_handshake_2, uP_data_oe, reg_write, reg_read}, reg_address, reg_wr_data);
    end
    reset = 1'b0;
    rw_in = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ((wr_cnt - wb) !== 0 || (rd_cnt - rb) !== 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_strobe: got wr %0d rd %0d expected 0 0", wr_cnt - wb, rd_cnt - rb);
    end
    send_cmd(8'd1, 8'h20, 32'h1234_5678, 1'b0);
    recv_reply(reply, oe_ok);
    n_cmp++;
    if ((wr_cnt - wb) !== 1 || last_addr !== 8'h20 || last_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL midreset_write: got %0d %h %h expected 1 20 12345678",
               wr_cnt - wb, last_addr, last_wdata);
    end
    n_cmp++;
    if (reply !== {STATUS_OK, 32'h1234_5678}) begin
      n_fail++;
      $display("[TB] FAIL midreset_reply: got %h expected %h", reply, {STATUS_OK, 32'h1234_5678});
    end
  endtask

  task automatic test_rw_guard();
    logic [63:0] reply;
    bit          oe_ok;
    int          viol;
    send_cmd(8'd1, 8'h30, 32'hCAFE_F00D, 1'b0);
    // Host keeps claiming the bus while the block reaches TX_DRIVE.
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (uP_data_oe !== 1'b0 || uP_handshake_2 !== 1'b0) viol++;
    end
    n_cmp++;
    if (viol !== 0) begin
      n_fail++;
      $display("[TB] FAIL guard_oe: got %0d driven cycles expected 0", viol);
    end
    n_cmp++;
    if (uP_ack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL guard_wait: got ack %b expected 0", uP_ack);
    end
    recv_reply(reply, oe_ok);
    n_cmp++;
    if (reply !== {STATUS_OK, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("[TB] FAIL guard_reply: got %h expected %h", reply, {STATUS_OK, 32'hCAFE_F00D});
    end
    n_cmp++;
    if (oe_ok !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL guard_oe_release: got %b expected 1", oe_ok);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] reply;
    bit          oe_ok;
    model_hold = 1'b1;
    send_cmd(8'd0, 8'h40, 32'h0, 1'b0);
`ifdef UP_TIMEOUT_EN
    recv_reply(reply, oe_ok);
    n_cmp++;
    if (reply !== {32'h0000_0002, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL timeout_reply: got %h expected %h", reply, {32'h0000_0002, 32'h0});
    end
    n_cmp++;
    if (uP_ack !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL timeout_ack: got %b expected 1", uP_ack);
    end
`else
    rw_in = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if ({uP_ack, uP_handshake_2, uP_data_oe} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL hold_wait: got %b expected 000", {uP_ack, uP_handshake_2, uP_data_oe});
    end
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_hold = 1'b0;
    repeat (3) @(negedge clk);
    send_cmd(8'd0, 8'h20, 32'h0, 1'b0);
    recv_reply(reply, oe_ok);
    n_cmp++;
    if (reply !== {STATUS_OK, 32'h1234_5678}) begin
      n_fail++;
      $display("[TB] FAIL recover_reply: got %h expected %h", reply, {STATUS_OK, 32'h1234_5678});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_reset_mid_packet();
    test_rw_guard();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/up_packet_bridge.md
UP_PACKET_BRIDGE -- requirements
Module: up_packet_bridge

Interface
REQ-001 SHALL have parameter NOS_CMD_BYTES, default 6, command packet length in bytes: cmd, addr, data[7:0], [15:8], [23:16], [31:24].
REQ-002 SHALL have parameter NOS_REPLY_BYTES, default 8, reply length in bytes: data[7:0] to data[31:24], then status[7:0] to status[31:24].
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000, stall limit in clk cycles.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 async_uP_start  input  1  host transaction start, asynchronous.
REQ-007 async_uP_handshake_1  input  1  host strobe/ack, asynchronous.
REQ-008 async_uP_RW  input  1  1 = host drives bus, asynchronous.
REQ-009 uP_data_in  input  8  byte from host.
REQ-010 uP_data_out  output  8  byte to host.
REQ-011 uP_data_oe  output  1  enables the external tristate onto uP_data.
REQ-012 uP_handshake_2  output  1  block strobe/ack.
REQ-013 uP_ack  output  1  transaction complete.
REQ-014 reg_address  output  8 / reg_wr_data  output  32 / reg_write, reg_read  output  1 each: register-bank request.
REQ-015 reg_rd_data  input  32 / reg_status  input  32 / reg_done  input  1: register-bank response.

Function
REQ-016 Each async input SHALL pass through a 2-flop synchronizer; all control decisions use synchronized values only (2-cycle input latency).
REQ-017 States SHALL be: IDLE, RX_WAIT_H1, RX_WAIT_H1_LOW, EXECUTE, WAIT_DONE, TX_DRIVE, TX_WAIT_H1, TX_WAIT_H1_LOW, COMPLETE.
REQ-018 IDLE -> RX_WAIT_H1 on a synchronized rising edge of start; uP_ack cleared, byte counter = 0.
REQ-019 RX_WAIT_H1: when h1=1 and RW=1, latch uP_data_in into byte[counter], set uP_handshake_2=1, go RX_WAIT_H1_LOW.
REQ-020 RX_WAIT_H1_LOW: when h1=0, clear uP_handshake_2 and increment counter; go EXECUTE if counter reached NOS_CMD_BYTES, else RX_WAIT_H1.
REQ-021 EXECUTE: cmd 0 -> pulse reg_read for 1 cycle; cmd 1 -> pulse reg_write for 1 cycle; reg_address = byte1 and reg_wr_data = bytes 5..2, both held stable until WAIT_DONE exits; go WAIT_DONE.
REQ-022 Any other cmd SHALL set bad_cmd flag, issue no strobe, use reply data 0, and go directly to TX_DRIVE.
REQ-023 WAIT_DONE: on reg_done=1, capture reply data = reg_rd_data (read) or reg_wr_data echo (write), capture reg_status, go TX_DRIVE.
REQ-024 Reply status SHALL be {reg_status[31:2], timeout_flag, bad_cmd_flag}.
REQ-025 TX_DRIVE: when RW=0, drive uP_data_out = reply byte[counter], assert uP_data_oe, one cycle later raise uP_handshake_2, go TX_WAIT_H1.
REQ-026 TX_WAIT_H1: when h1=1, clear uP_handshake_2, go TX_WAIT_H1_LOW; TX_WAIT_H1_LOW: when h1=0, increment counter; go COMPLETE after NOS_REPLY_BYTES bytes, else TX_DRIVE.
REQ-027 uP_data_oe SHALL be 0 in every state except TX_*, and whenever synchronized RW=1 (bus contention guard).
REQ-028 COMPLETE: set uP_ack=1, go IDLE; uP_ack holds until the next start rising edge or reset.
REQ-029 A start rising edge while not IDLE SHALL be ignored.
REQ-030 h1 changes in a state not waiting for them SHALL be ignored.

Reset
REQ-031 reset=1 at any clk edge, including mid-transaction, SHALL force IDLE, counter 0, flags 0, all outputs 0, with no register strobe emitted.

Configuration
REQ-032 Macro UP_TIMEOUT_EN defined: a counter SHALL restart on each state change, and reaching TIMEOUT_CYCLES in any non-IDLE state SHALL set timeout_flag. In RX/EXECUTE/WAIT_DONE this goes to TX_DRIVE with reply data 0; in TX states it goes to COMPLETE.
REQ-033 Without UP_TIMEOUT_EN: no timeout counter, timeout_flag tied 0, and states wait indefinitely.

Verification
REQ-034 Write: cmd 1, addr 0x10, data 100 -> single reg_write pulse, reg_address 0x10, reg_wr_data 100; reply data 100, status bits[1:0] 00, uP_ack=1.
REQ-035 Read: after REQ-034, cmd 0, addr 0x10, model returns 100 -> single reg_read pulse, reply bytes 64 00 00 00 then status.
REQ-036 Bad cmd 7 -> no reg strobes, reply data 0, status bit0=1.
REQ-037 reset asserted after 3rd received byte -> IDLE, outputs 0; next full transaction succeeds.
REQ-038 UP_TIMEOUT_EN, TIMEOUT_CYCLES 50, reg_done never asserted -> status bit1=1 and reply data 0; without the macro -> block holds WAIT_DONE.
REQ-039 Host asserts RW=1 during TX_DRIVE -> uP_data_oe stays 0 until RW returns 0.
